// File: rtl/reservation_station.sv
// Tomasulo reservation station: tagged entries wait on the common data bus,
// dispatch lowest-index READY entry to the FU, free on broadcast of own tag.
module reservation_station #(
  parameter int DEPTH        = 4,
  parameter int DATA_W       = 32,
  parameter int LABEL_W      = 5,
  parameter int STATION_BASE = 1
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  output logic [LABEL_W-1:0]         issue_label,
  input  logic [5:0]                 issue_op,
  input  logic [5:0]                 issue_func,
  input  logic [DATA_W-1:0]          issue_rs_data,
  input  logic [DATA_W-1:0]          issue_rt_data,
  input  logic [LABEL_W-1:0]         issue_rs_label,
  input  logic [LABEL_W-1:0]         issue_rt_label,
  input  logic                       BCEN,
  input  logic [LABEL_W-1:0]         BClabel,
  input  logic [DATA_W-1:0]          BCdata,
  output logic                       disp_valid,
  input  logic                       disp_ready,
  output logic [5:0]                 disp_op,
  output logic [5:0]                 disp_func,
  output logic [DATA_W-1:0]          disp_a,
  output logic [DATA_W-1:0]          disp_b,
  output logic [LABEL_W-1:0]         disp_label,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_EXEC} state_t;

  state_t              r_state [DEPTH];
  logic [5:0]          r_op    [DEPTH];
  logic [5:0]          r_func  [DEPTH];
  logic [DATA_W-1:0]   r_a     [DEPTH];
  logic [DATA_W-1:0]   r_b     [DEPTH];
  logic [LABEL_W-1:0]  r_la    [DEPTH];
  logic [LABEL_W-1:0]  r_lb    [DEPTH];

  logic [IDX_W-1:0]    w_iss_idx, w_disp_idx;
  logic                w_any_free, w_any_ready;
  logic [OCC_W-1:0]    w_occ;
  logic                w_issue, w_disp;
  logic                w_byp_a, w_byp_b;
  logic [DATA_W-1:0]   w_new_a, w_new_b;
  logic [LABEL_W-1:0]  w_new_la, w_new_lb;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    w_iss_idx   = '0;
    w_disp_idx  = '0;
    w_any_free  = 1'b0;
    w_any_ready = 1'b0;
    w_occ       = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (r_state[i] == S_FREE) begin
        w_any_free = 1'b1;
        w_iss_idx  = IDX_W'(i);
      end
      if (r_state[i] == S_READY) begin
        w_any_ready = 1'b1;
        w_disp_idx  = IDX_W'(i);
      end
      if (r_state[i] != S_FREE) w_occ = w_occ + OCC_W'(1);
    end
  end

  assign w_issue = issue_valid && w_any_free;
  assign w_disp  = w_any_ready && disp_ready;

  // Same-cycle bus bypass into the issuing operands.
  assign w_byp_a  = BCEN && (issue_rs_label != '0) && (issue_rs_label == BClabel);
  assign w_byp_b  = BCEN && (issue_rt_label != '0) && (issue_rt_label == BClabel);
  assign w_new_a  = w_byp_a ? BCdata : issue_rs_data;
  assign w_new_b  = w_byp_b ? BCdata : issue_rt_data;
  assign w_new_la = w_byp_a ? '0 : issue_rs_label;
  assign w_new_lb = w_byp_b ? '0 : issue_rt_label;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    localparam logic [LABEL_W-1:0] TAG = LABEL_W'(STATION_BASE + g);
    logic w_hit_a, w_hit_b;
    assign w_hit_a = BCEN && (r_la[g] != '0) && (r_la[g] == BClabel);
    assign w_hit_b = BCEN && (r_lb[g] != '0) && (r_lb[g] == BClabel);

    always_ff @(posedge clk) begin
      if (nRST) begin
        r_state[g] <= S_FREE;
        r_op[g]    <= '0;
        r_func[g]  <= '0;
        r_a[g]     <= '0;
        r_b[g]     <= '0;
        r_la[g]    <= '0;
        r_lb[g]    <= '0;
      end else begin
        case (r_state[g])
          S_FREE: if (w_issue && (w_iss_idx == IDX_W'(g))) begin
            r_op[g]    <= issue_op;
            r_func[g]  <= issue_func;
            r_a[g]     <= w_new_a;
            r_b[g]     <= w_new_b;
            r_la[g]    <= w_new_la;
            r_lb[g]    <= w_new_lb;
            r_state[g] <= (w_new_la == '0 && w_new_lb == '0) ? S_READY : S_WAIT;
          end
          S_WAIT: begin
            if (w_hit_a) begin
              r_a[g]  <= BCdata;
              r_la[g] <= '0;
            end
            if (w_hit_b) begin
              r_b[g]  <= BCdata;
              r_lb[g] <= '0;
            end
            if ((w_hit_a || r_la[g] == '0) && (w_hit_b || r_lb[g] == '0))
              r_state[g] <= S_READY;
          end
          S_READY: if (w_disp && (w_disp_idx == IDX_W'(g))) r_state[g] <= S_EXEC;
          // Own-tag broadcasts in WAIT/READY are protocol errors and fall through here.
          S_EXEC:  if (BCEN && (BClabel == TAG)) r_state[g] <= S_FREE;
          default: r_state[g] <= S_FREE;
        endcase
      end
    end
  end

  assign issue_ready = w_any_free;
  assign issue_label = LABEL_W'(STATION_BASE) + LABEL_W'(w_iss_idx);
  assign disp_valid  = w_any_ready;
  assign disp_op     = w_any_ready ? r_op[w_disp_idx]   : '0;
  assign disp_func   = w_any_ready ? r_func[w_disp_idx] : '0;
  assign disp_a      = w_any_ready ? r_a[w_disp_idx]    : '0;
  assign disp_b      = w_any_ready ? r_b[w_disp_idx]    : '0;
  assign disp_label  = w_any_ready ? (LABEL_W'(STATION_BASE) + LABEL_W'(w_disp_idx)) : '0;
  assign occupancy   = w_occ;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: expected dispatches are queued by
// the stimulus and popped by a monitor on every accepted dispatch.
module tb_reservation_station;
  logic        clk = 1'b0;
  logic        nRST;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_label;
  logic [5:0]  issue_op, issue_func;
  logic [31:0] issue_rs_data, issue_rt_data;
  logic [4:0]  issue_rs_label, issue_rt_label;
  logic        BCEN;
  logic [4:0]  BClabel;
  logic [31:0] BCdata;
  logic        disp_valid, disp_ready;
  logic [5:0]  disp_op, disp_func;
  logic [31:0] disp_a, disp_b;
  logic [4:0]  disp_label;
  logic [2:0]  occupancy;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  lab;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_pass = 0;

  reservation_station #(.DEPTH(4), .DATA_W(32), .LABEL_W(5), .STATION_BASE(1)) dut (
    .clk(clk), .nRST(nRST),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_label(issue_label),
    .issue_op(issue_op), .issue_func(issue_func),
    .issue_rs_data(issue_rs_data), .issue_rt_data(issue_rt_data),
    .issue_rs_label(issue_rs_label), .issue_rt_label(issue_rt_label),
    .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_func(disp_func), .disp_a(disp_a), .disp_b(disp_b),
    .disp_label(disp_label), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] func,
                       input logic [31:0] a, input logic [4:0] la,
                       input logic [31:0] b, input logic [4:0] lb);
    issue_op = op; issue_func = func;
    issue_rs_data = a; issue_rs_label = la;
    issue_rt_data = b; issue_rt_label = lb;
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic bcast(input logic [4:0] lab, input logic [31:0] d);
    BCEN = 1'b1; BClabel = lab; BCdata = d;
    step();
    BCEN = 1'b0;
  endtask

  task automatic push(input logic [5:0] op, input logic [5:0] func,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] lab);
    exp_t e;
    e.op = op; e.func = func; e.a = a; e.b = b; e.lab = lab;
    q.push_back(e);
  endtask

  // Monitor: every accepted dispatch must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!nRST && disp_valid && disp_ready) begin
      if (q.size() == 0) begin
        chk("disp_unexpected", 64'(disp_label), 64'hFFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("disp_op",    64'(disp_op),    64'(e.op));
        chk("disp_func",  64'(disp_func),  64'(e.func));
        chk("disp_a",     64'(disp_a),     64'(e.a));
        chk("disp_b",     64'(disp_b),     64'(e.b));
        chk("disp_label", 64'(disp_label), 64'(e.lab));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b1; issue_valid = 1'b0; disp_ready = 1'b0;
    issue_op = '0; issue_func = '0; issue_rs_data = '0; issue_rt_data = '0;
    issue_rs_label = '0; issue_rt_label = '0;
    BCEN = 1'b0; BClabel = '0; BCdata = '0;
    step(); step();
    nRST = 1'b0;

    // Reset state
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_issue_label", 64'(issue_label), 64'd1);
    chk("rst_disp_valid",  64'(disp_valid),  64'd0);
    chk("rst_occupancy",   64'(occupancy),   64'd0);

    // Ready operands: dispatchable next cycle, then execute and release
    issue(6'h00, 6'h20, 32'd5, 5'd0, 32'd7, 5'd0);
    chk("t2_disp_valid", 64'(disp_valid), 64'd1);
    chk("t2_occupancy",  64'(occupancy),  64'd1);
    push(6'h00, 6'h20, 32'd5, 32'd7, 5'd1);
    disp_ready = 1'b1; step(); disp_ready = 1'b0;
    chk("t2_exec_disp_valid", 64'(disp_valid), 64'd0);
    chk("t2_exec_occupancy",  64'(occupancy),  64'd1);
    bcast(5'd1, 32'h0);
    chk("t2_release_occ", 64'(occupancy), 64'd0);

    // Pending rs operand woken by broadcast of label 9
    issue(6'h01, 6'h02, 32'hAAAA, 5'd9, 32'd3, 5'd0);
    chk("t3_wait_disp_valid", 64'(disp_valid), 64'd0);
    bcast(5'd9, 32'h1234);
    chk("t3_wake_disp_valid", 64'(disp_valid), 64'd1);
    chk("t3_wake_disp_a",     64'(disp_a),     64'h1234);
    push(6'h01, 6'h02, 32'h1234, 32'd3, 5'd1);
    disp_ready = 1'b1; step(); disp_ready = 1'b0;
    bcast(5'd1, 32'h0);
    chk("t3_release_occ", 64'(occupancy), 64'd0);

    // Issue-cycle bypass of rt from the bus
    BCEN = 1'b1; BClabel = 5'd9; BCdata = 32'hBEEF;
    issue(6'h03, 6'h04, 32'h11, 5'd0, 32'h0, 5'd9);
    BCEN = 1'b0;
    chk("t4_disp_valid", 64'(disp_valid), 64'd1);
    chk("t4_disp_b",     64'(disp_b),     64'hBEEF);
    push(6'h03, 6'h04, 32'h11, 32'hBEEF, 5'd1);
    disp_ready = 1'b1; step(); disp_ready = 1'b0;
    bcast(5'd1, 32'h0);
    chk("t4_release_occ", 64'(occupancy), 64'd0);

    // Fill all four entries, each waiting on label 20
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_label_%0d", k), 64'(issue_label), 64'(k + 1));
      issue(6'(8 + k), 6'(16 + k), 32'h0, 5'd20, 32'(100 + k), 5'd0);
    end
    chk("t5_full_ready", 64'(issue_ready), 64'd0);
    chk("t5_full_occ",   64'(occupancy),   64'd4);
    chk("t5_full_dispv", 64'(disp_valid),  64'd0);
    issue(6'h3F, 6'h3F, 32'd1, 5'd0, 32'd2, 5'd0);
    chk("t5_ignored_occ",   64'(occupancy),   64'd4);
    chk("t5_ignored_ready", 64'(issue_ready), 64'd0);

    // Wake all, dispatch tags 1 and 2 back to back
    bcast(5'd20, 32'h55);
    chk("t5_wake_label", 64'(disp_label), 64'd1);
    chk("t5_wake_a",     64'(disp_a),     64'h55);
    push(6'd8, 6'd16, 32'h55, 32'd100, 5'd1);
    push(6'd9, 6'd17, 32'h55, 32'd101, 5'd2);
    disp_ready = 1'b1; step(); step(); disp_ready = 1'b0;

    // Tags 3,4 READY with FU stalled: head holds, nothing consumed
    chk("t6_hold_label0", 64'(disp_label), 64'd3);
    chk("t6_hold_b0",     64'(disp_b),     64'd102);
    step();
    chk("t6_hold_label1", 64'(disp_label), 64'd3);
    chk("t6_hold_valid1", 64'(disp_valid), 64'd1);
    chk("t6_hold_occ",    64'(occupancy),  64'd4);

    // Release tag 2 reopens entry 1
    bcast(5'd2, 32'h0);
    chk("t5_rel_label", 64'(issue_label), 64'd2);
    chk("t5_rel_ready", 64'(issue_ready), 64'd1);
    chk("t5_rel_occ",   64'(occupancy),   64'd3);

    // Mid-stream reset overrides same-cycle issue and broadcast
    nRST = 1'b1; BCEN = 1'b1; BClabel = 5'd1; BCdata = 32'h77;
    issue(6'h05, 6'h06, 32'd9, 5'd0, 32'd9, 5'd0);
    nRST = 1'b0; BCEN = 1'b0;
    chk("rst2_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst2_issue_label", 64'(issue_label), 64'd1);
    chk("rst2_disp_valid",  64'(disp_valid),  64'd0);
    chk("rst2_disp_a",      64'(disp_a),      64'd0);
    chk("rst2_disp_label",  64'(disp_label),  64'd0);
    chk("rst2_occupancy",   64'(occupancy),   64'd0);
    step();
    chk("sb_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
